pm_loader: RTL and testbench
============================

// Module: pm_loader
// PURPOSE
//  Program-memory loader; sits directly upstream of main and drives its PMInputDone input.
//  Operator enters BF opcodes one byte at a time on SW[7:0] and commits each with a key press.
//  Accepted bytes are written sequentially into program memory from address 0.
//  A finish press writes a 0x00 terminator and asserts PMInputDone so main may start on go.
// PARAMETERS
//  ADDR_W   8    program-memory address width; DEPTH = 2**ADDR_W
//  DATA_W   8    program-memory word width (ASCII opcode)
//  TERM     8'h00 terminator word written on finish
// PORTS
//  clock        in   1       system clock
//  reset        in   1       async, active-high; clears all state
//  data_in      in   DATA_W  opcode byte from switches
//  enter        in   1       raw, asynchronous, active-high commit button
//  finish       in   1       raw, asynchronous, active-high end-of-program button
//  pm_we        out  1       program-memory write strobe, one cycle per write
//  pm_addr      out  ADDR_W  program-memory write address
//  pm_wdata     out  DATA_W  program-memory write data
//  PMInputDone  out  1       program loaded; held high until reset
//  count        out  ADDR_W  number of opcodes accepted, terminator excluded
//  reject       out  1       sticky: last committed byte was illegal or memory full
// BEHAVIOUR
//  Reset: pm_we=0, pm_addr=0, pm_wdata=0, PMInputDone=0, count=0, reject=0, state=LOAD, ptr=0.
//  Inputs: enter and finish each pass through a 2-FF synchronizer, then a rising-edge detector.
//   - An edge pulse lasts exactly one clock.
//   - A held button yields exactly one pulse.
//  Legal opcodes: '+' 2B, '-' 2D, '<' 3C, '>' 3E, '[' 5B, ']' 5D, '.' 2E, ',' 2C.
//  FSM states: LOAD, TERM, DONE. All outputs are registered.
//  LOAD, enter pulse, data_in legal, ptr < DEPTH-1:
//   - next cycle: pm_we=1, pm_addr=ptr, pm_wdata=data_in (sampled at the pulse).
//   - ptr++, count++, reject<=0.
//  LOAD, enter pulse, data_in illegal: no write; reject<=1; ptr unchanged.
//  LOAD, enter pulse, ptr == DEPTH-1 (full; last slot is reserved for TERM): no write; reject<=1.
//  LOAD, finish pulse -> TERM. Finish takes priority over a same-cycle enter pulse; that enter byte is discarded.
//  TERM: one cycle, pm_we=1, pm_addr=ptr, pm_wdata=TERM -> DONE.
//  DONE: PMInputDone=1; all enter/finish pulses ignored; pm_we=0; only reset leaves DONE.
//  Latency: input high at clock edge k -> synced at k+2 -> edge pulse -> pm_we high in cycle k+3.
//  An empty program (finish with no accepted bytes) writes TERM at address 0 and is valid.
//  Reset asserted mid-load or mid-TERM aborts immediately:
//   - pm_we drops asynchronously.
//   - memory contents are left as-is; the next load overwrites from address 0.
//  ptr never wraps; count saturates at DEPTH-1.
// STRUCTURE
//  Shared header bf_defs.vh:
//   - opcode constants (OP_INC, OP_DEC, OP_LEFT, OP_RIGHT, OP_LOOP, OP_END, OP_OUT, OP_IN).
//   - OP_TERM; also used by main's decoder.
//  Sub-module key_sync_edge: async input -> 2-FF sync -> one-cycle rising pulse; instantiated twice.
//  Opcode legality check: combinational function in pm_loader, built from the header constants.
// TESTING
//  1. Reset, commit 2B,3E,2E, then finish -> writes (0,2B),(1,3E),(2,2E),(3,00); count=3; PMInputDone=1.
//  2. Commit 41 ('A') -> no pm_we, reject=1; then commit 2D -> write (0,2D), reject=0.
//  3. Hold enter high for 20 cycles with data 2B -> exactly one write; pm_we rises 3 cycles after enter.
//  4. ADDR_W=2: commit 4 legal bytes -> 3 writes; 4th gives reject=1; finish writes 00 at addr 3.
//  5. Enter and finish rise in the same cycle -> only the TERM write at ptr; DONE; later enter ignored.
//  6. Reset asserted during TERM cycle -> pm_we=0 at once; PMInputDone=0, count=0; reload starts at addr 0.

Source files
------------

// File: rtl/pm_loader_pkg.sv
// Shared definitions for the program-memory loader: BF opcode bytes,
// the terminator word and the loader FSM state type.
package pm_loader_pkg;

  // ASCII encodings of the eight BF opcodes accepted by the loader
  localparam logic [7:0] OP_INC   = 8'h2B;  // '+'
  localparam logic [7:0] OP_DEC   = 8'h2D;  // '-'
  localparam logic [7:0] OP_LEFT  = 8'h3C;  // '<'
  localparam logic [7:0] OP_RIGHT = 8'h3E;  // '>'
  localparam logic [7:0] OP_LOOP  = 8'h5B;  // '['
  localparam logic [7:0] OP_END   = 8'h5D;  // ']'
  localparam logic [7:0] OP_OUT   = 8'h2E;  // '.'
  localparam logic [7:0] OP_IN    = 8'h2C;  // ','

  // End-of-program marker; main's decoder stops when it fetches this word
  localparam logic [7:0] OP_TERM  = 8'h00;

  // LOAD accepts bytes, TERM writes the terminator, DONE holds until reset
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_TERM = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pm_loader_key_sync_edge.sv
// Brings a raw push-button into the clock domain through two flops and
// turns each rising edge into a single-cycle pulse, however long it is held.
module key_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic key_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-stage synchronizer followed by a one-cycle history flop for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Both terms come from flops, so the pulse is clean and exactly one clock wide
  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/pm_loader.sv
// Program-memory loader: the operator commits BF opcodes one at a time from
// the switches; legal bytes are written sequentially from address 0, and a
// finish press appends the terminator and raises PMInputDone for main.
module pm_loader
  import pm_loader_pkg::*;
#(
  parameter int              ADDR_W = 8,
  parameter int              DATA_W = 8,
  parameter logic [DATA_W-1:0] TERM = DATA_W'(OP_TERM)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enter,
  input  logic              finish,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              PMInputDone,
  output logic [ADDR_W-1:0] count,
  output logic              reject
);

  // The top address is kept free so the terminator always fits
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  logic enterPulse;
  logic finishPulse;

  state_e            state_q,  state_d;
  logic [ADDR_W-1:0] ptr_q,    ptr_d;
  logic [ADDR_W-1:0] count_q,  count_d;
  logic              reject_q, reject_d;
  logic              we_q,     we_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic              done_q,   done_d;

  // True only for the eight BF opcode characters
  function automatic logic isLegal(input logic [DATA_W-1:0] op);
    return (op == DATA_W'(OP_INC))   || (op == DATA_W'(OP_DEC))  ||
           (op == DATA_W'(OP_LEFT))  || (op == DATA_W'(OP_RIGHT)) ||
           (op == DATA_W'(OP_LOOP))  || (op == DATA_W'(OP_END))  ||
           (op == DATA_W'(OP_OUT))   || (op == DATA_W'(OP_IN));
  endfunction

  key_sync_edge u_enterSync (
    .clock  (clock),
    .reset  (reset),
    .key_i  (enter),
    .pulse_o(enterPulse)
  );

  key_sync_edge u_finishSync (
    .clock  (clock),
    .reset  (reset),
    .key_i  (finish),
    .pulse_o(finishPulse)
  );

  // State and registered outputs; reset also kills an in-flight write strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      ptr_q    <= '0;
      count_q  <= '0;
      reject_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      reject_q <= reject_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; the terminator write is launched on the finish pulse so
  // the strobe is high exactly while the FSM sits in TERM
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    reject_d = reject_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = done_q;

    case (state_q)
      ST_LOAD: begin
        if (finishPulse) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = TERM;
          state_d = ST_TERM;
        end else if (enterPulse) begin
          if (!isLegal(data_in) || (ptr_q == PTR_LAST)) begin
            reject_d = 1'b1;
          end else begin
            we_d     = 1'b1;
            addr_d   = ptr_q;
            wdata_d  = data_in;
            ptr_d    = ptr_q + 1'b1;
            count_d  = (count_q == PTR_LAST) ? count_q : count_q + 1'b1;
            reject_d = 1'b0;
          end
        end
      end
      ST_TERM: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign pm_we       = we_q;
  assign pm_addr     = addr_q;
  assign pm_wdata    = wdata_q;
  assign PMInputDone = done_q;
  assign count       = count_q;
  assign reject      = reject_q;

endmodule

// File: tb/tb_pm_loader.sv
// Scoreboard bench for pm_loader: stimulus pushes the expected memory writes,
// per-instance monitors pop and compare whenever pm_we is seen high.
module tb_pm_loader;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  // Full-size instance
  logic [7:0] dataInA;
  logic       enterA, finishA;
  logic       pmWeA, doneA, rejectA;
  logic [7:0] pmAddrA, pmWdataA, countA;

  // Tiny instance with a four-word memory for the full-memory case
  logic [7:0] dataInB;
  logic       enterB, finishB;
  logic       pmWeB, doneB, rejectB;
  logic [1:0] pmAddrB, countB;
  logic [7:0] pmWdataB;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t expA[$];
  wr_t expB[$];

  int testsRun    = 0;
  int testsFailed = 0;

  pm_loader #(.ADDR_W(8), .DATA_W(8), .TERM(8'h00)) dutA (
    .clock      (clock),
    .reset      (reset),
    .data_in    (dataInA),
    .enter      (enterA),
    .finish     (finishA),
    .pm_we      (pmWeA),
    .pm_addr    (pmAddrA),
    .pm_wdata   (pmWdataA),
    .PMInputDone(doneA),
    .count      (countA),
    .reject     (rejectA)
  );

  pm_loader #(.ADDR_W(2), .DATA_W(8), .TERM(8'h00)) dutB (
    .clock      (clock),
    .reset      (reset),
    .data_in    (dataInB),
    .enter      (enterB),
    .finish     (finishB),
    .pm_we      (pmWeB),
    .pm_addr    (pmAddrB),
    .pm_wdata   (pmWdataB),
    .PMInputDone(doneB),
    .count      (countB),
    .reject     (rejectB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Press a button: raise it one cycle after a clock edge, hold, release, settle
  task automatic applyStimulus(input bit useB, input logic [7:0] data,
                               input bit doEnter, input bit doFinish, input int hold);
    @(posedge clock); #1;
    if (useB) begin
      dataInB = data; enterB = doEnter; finishB = doFinish;
    end else begin
      dataInA = data; enterA = doEnter; finishA = doFinish;
    end
    repeat (hold) @(posedge clock);
    #1;
    if (useB) begin
      enterB = 1'b0; finishB = 1'b0;
    end else begin
      enterA = 1'b0; finishA = 1'b0;
    end
    repeat (6) @(posedge clock);
    #1;
  endtask

  // Count clock edges until the write strobe of instance A appears (bounded)
  task automatic waitWeA(output int cycles);
    cycles = 0;
    do begin
      @(posedge clock); #1;
      cycles++;
    end while (!pmWeA && cycles < 12);
    if (!pmWeA) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL waitWeA: pm_we never rose within %0d cycles", cycles);
    end
  endtask

  // Monitor for instance A
  always @(negedge clock) begin
    if (pmWeA === 1'b1) begin
      if (expA.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL A unexpected write: addr %0h data %0h, expected none",
                 pmAddrA, pmWdataA);
      end else begin
        wr_t e;
        e = expA.pop_front();
        checkOutput("A write addr", 32'(pmAddrA), 32'(e.addr));
        checkOutput("A write data", 32'(pmWdataA), 32'(e.data));
      end
    end
  end

  // Monitor for instance B
  always @(negedge clock) begin
    if (pmWeB === 1'b1) begin
      if (expB.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL B unexpected write: addr %0h data %0h, expected none",
                 pmAddrB, pmWdataB);
      end else begin
        wr_t e;
        e = expB.pop_front();
        checkOutput("B write addr", 32'(pmAddrB), 32'(e.addr));
        checkOutput("B write data", 32'(pmWdataB), 32'(e.data));
      end
    end
  end

  // Watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    reset   = 1'b1;
    dataInA = 8'h00; enterA = 1'b0; finishA = 1'b0;
    dataInB = 8'h00; enterB = 1'b0; finishB = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset pm_we",       32'(pmWeA),    0);
    checkOutput("reset pm_addr",     32'(pmAddrA),  0);
    checkOutput("reset pm_wdata",    32'(pmWdataA), 0);
    checkOutput("reset PMInputDone", 32'(doneA),    0);
    checkOutput("reset count",       32'(countA),   0);
    checkOutput("reset reject",      32'(rejectA),  0);
    @(negedge clock);
    reset = 1'b0;

    // Four-word memory: three bytes fit, the fourth is refused, TERM lands in slot 3
    expB.push_back('{8'd0, 8'h2B});
    expB.push_back('{8'd1, 8'h2D});
    expB.push_back('{8'd2, 8'h3C});
    applyStimulus(1, 8'h2B, 1, 0, 2);
    applyStimulus(1, 8'h2D, 1, 0, 2);
    applyStimulus(1, 8'h3C, 1, 0, 2);
    checkOutput("B reject before full", 32'(rejectB), 0);
    applyStimulus(1, 8'h3E, 1, 0, 2);
    checkOutput("B reject when full", 32'(rejectB), 1);
    checkOutput("B count when full",  32'(countB),  3);
    expB.push_back('{8'd3, 8'h00});
    applyStimulus(1, 8'h00, 0, 1, 2);
    checkOutput("B PMInputDone", 32'(doneB), 1);

    // Simple program: three opcodes then terminator
    expA.push_back('{8'd0, 8'h2B});
    expA.push_back('{8'd1, 8'h3E});
    expA.push_back('{8'd2, 8'h2E});
    applyStimulus(0, 8'h2B, 1, 0, 2);
    applyStimulus(0, 8'h3E, 1, 0, 2);
    applyStimulus(0, 8'h2E, 1, 0, 2);
    checkOutput("A count after 3", 32'(countA), 3);
    checkOutput("A done before finish", 32'(doneA), 0);
    expA.push_back('{8'd3, 8'h00});
    applyStimulus(0, 8'h00, 0, 1, 2);
    checkOutput("A PMInputDone", 32'(doneA), 1);
    checkOutput("A count final", 32'(countA), 3);
    applyStimulus(0, 8'h2D, 1, 0, 2);
    checkOutput("A count after DONE enter", 32'(countA), 3);

    // Illegal byte then a legal one
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    applyStimulus(0, 8'h41, 1, 0, 2);
    checkOutput("A reject illegal", 32'(rejectA), 1);
    checkOutput("A count illegal",  32'(countA),  0);
    expA.push_back('{8'd0, 8'h2D});
    applyStimulus(0, 8'h2D, 1, 0, 2);
    checkOutput("A reject cleared", 32'(rejectA), 0);
    checkOutput("A count legal",    32'(countA),  1);

    // Held button: one write, three edges after the press
    expA.push_back('{8'd1, 8'h2B});
    @(posedge clock); #1;
    dataInA = 8'h2B;
    enterA  = 1'b1;
    waitWeA(lat);
    checkOutput("A enter latency", 32'(lat), 3);
    repeat (20 - lat) @(posedge clock);
    #1;
    enterA = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    checkOutput("A count after hold", 32'(countA), 2);

    // Enter and finish together: only the terminator is written
    expA.push_back('{8'd2, 8'h00});
    applyStimulus(0, 8'h3C, 1, 1, 2);
    checkOutput("A done after tie",  32'(doneA),  1);
    checkOutput("A count after tie", 32'(countA), 2);
    applyStimulus(0, 8'h3C, 1, 0, 2);
    checkOutput("A count ignored in DONE", 32'(countA), 2);

    // Reset during the terminator write
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    expA.push_back('{8'd0, 8'h2B});
    expA.push_back('{8'd1, 8'h2B});
    applyStimulus(0, 8'h2B, 1, 0, 2);
    applyStimulus(0, 8'h2B, 1, 0, 2);
    @(posedge clock); #1;
    finishA = 1'b1;
    waitWeA(lat);
    checkOutput("A TERM addr before abort", 32'(pmAddrA), 2);
    reset = 1'b1;
    #1;
    checkOutput("A pm_we after abort",       32'(pmWeA), 0);
    checkOutput("A PMInputDone after abort", 32'(doneA), 0);
    checkOutput("A count after abort",       32'(countA), 0);
    finishA = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    expA.push_back('{8'd0, 8'h2C});
    applyStimulus(0, 8'h2C, 1, 0, 2);
    checkOutput("A count after reload", 32'(countA), 1);

    checkOutput("A scoreboard drained", 32'(expA.size()), 0);
    checkOutput("B scoreboard drained", 32'(expB.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
